// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - serial 8N1 dump of a register file's debug read port
// Optional sync-byte header (0xA5) enabled by defining REG_DUMP_HEADER_EN.
`timescale 1ns/1ps
module reg_dump_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_REGS     = 4,
  parameter int SEL_WIDTH    = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [7:0]           RegData,
  output logic [SEL_WIDTH-1:0] RegSel,
  output logic                 TxD,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]        BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST  = SEL_WIDTH'(NUM_REGS - 1);

`ifdef REG_DUMP_HEADER_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_HDR_LOAD} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state_q;
  logic [CW-1:0]        baud_q;
  logic [2:0]           bit_q;
  logic [7:0]           shift_q;
  logic [SEL_WIDTH-1:0] idx_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef REG_DUMP_HEADER_EN
  logic                 hdr_q;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG_DUMP_HEADER_EN
      hdr_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (Start) begin
            idx_q  <= '0;
            busy_q <= 1'b1;
            baud_q <= '0;
            bit_q  <= '0;
`ifdef REG_DUMP_HEADER_EN
            state_q <= S_HDR_LOAD;
`else
            state_q <= S_LOAD;
`endif
          end
        end
        // RegData is sampled only here, so later writes never touch the byte in flight
        S_LOAD: begin
          shift_q <= RegData;
`ifdef REG_DUMP_HEADER_EN
          hdr_q   <= 1'b0;
`endif
          txd_q   <= 1'b0;
          baud_q  <= '0;
          state_q <= S_START;
        end
`ifdef REG_DUMP_HEADER_EN
        S_HDR_LOAD: begin
          shift_q <= 8'hA5;
          hdr_q   <= 1'b1;
          txd_q   <= 1'b0;
          baud_q  <= '0;
          state_q <= S_START;
        end
`endif
        S_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              txd_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            bit_q  <= '0;
`ifdef REG_DUMP_HEADER_EN
            if (hdr_q) begin
              hdr_q   <= 1'b0;
              state_q <= S_LOAD;
            end else
`endif
            if (idx_q == SEL_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + SEL_WIDTH'(1);
              state_q <= S_LOAD;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RegSel = idx_q;
  assign TxD    = txd_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb/tb_reg_dump_tx.sv - scoreboard bench for reg_dump_tx (honours REG_DUMP_HEADER_EN)
`timescale 1ns/1ps
module tb_reg_dump_tx;

  localparam int C   = 4;
  localparam int N   = 4;
  localparam int C2  = 2;
  localparam int BC  = 1 + 10 * C;
  localparam int BC2 = 1 + 10 * C2;
`ifdef REG_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, start2;
  logic [7:0] regs [4];
  logic [7:0] rdata;
  logic [1:0] sel;
  logic       txd, busy, done;
  logic [0:0] sel2;
  logic       txd2, busy2, done2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int done_cnt = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  assign rdata = regs[sel];

  reg_dump_tx #(.CLKS_PER_BIT(C), .NUM_REGS(N), .SEL_WIDTH(2)) u_dut (
    .CLK(clk), .Reset(rst), .Start(start), .RegData(rdata),
    .RegSel(sel), .TxD(txd), .Busy(busy), .Done(done)
  );

  reg_dump_tx #(.CLKS_PER_BIT(C2), .NUM_REGS(1), .SEL_WIDTH(1)) u_dut_min (
    .CLK(clk), .Reset(rst), .Start(start2), .RegData(8'h00),
    .RegSel(sel2), .TxD(txd2), .Busy(busy2), .Done(done2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // UART decoder: samples mid-bit and pops the scoreboard; a reset during a byte drops it
  always begin : mon
    logic [7:0] b;
    logic       ab, sbit, pbit;
    @(negedge clk);
    if (rst === 1'b0 && txd === 1'b0) begin
      ab = 1'b0;
      repeat (C / 2) begin @(negedge clk); if (rst) ab = 1'b1; end
      sbit = txd;
      for (int k = 0; k < 8; k++) begin
        repeat (C) begin @(negedge clk); if (rst) ab = 1'b1; end
        b[k] = txd;
      end
      repeat (C) begin @(negedge clk); if (rst) ab = 1'b1; end
      pbit = txd;
      if (!ab) begin
        check_eq("start_bit", 32'(sbit), 0);
        check_eq("stop_bit", 32'(pbit), 1);
        if (sb.size() == 0) check_eq("sb_underflow", 0, 1);
        else check_eq("tx_byte", 32'(b), 32'(sb.pop_front()));
      end
    end
  end

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    if (HDR == 1) sb.push_back(8'hA5);
    sb.push_back(a); sb.push_back(b); sb.push_back(c); sb.push_back(d);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; t0 = cyc;
  endtask

  task automatic wait_to(input int d);
    while (cyc - t0 < d) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int exp_d);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check_eq(tag, (done === 1'b1) ? 32'(cyc - t0) : 32'hFFFF_FFFF, 32'(exp_d));
  endtask

  function automatic logic exp_bit2(input int d);
    int j = d / BC2;
    int o = d % BC2;
    logic [7:0] v = (HDR == 1 && j == 0) ? 8'hA5 : 8'h00;
    if (o == 0) return 1'b1;
    if (o <= C2) return 1'b0;
    if (o <= 9 * C2) return v[3'((o - C2 - 1) / C2)];
    return 1'b1;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dc0, n;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h80; regs[3] = 8'hFF;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", 32'(txd), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_regsel", 32'(sel), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic dump, RegSel sequence and latency
    push_frame(8'h11, 8'h22, 8'h80, 8'hFF);
    pulse_start();
    check_eq("busy_rise", 32'(busy), 1);
    check_eq("load_txd", 32'(txd), 1);
    check_eq("regsel_0", 32'(sel), 0);
    wait_to(1);
    check_eq("txd_fall", 32'(txd), 0);
    for (int k = 1; k < N; k++) begin
      wait_to((k + HDR) * BC);
      check_eq("regsel_load", 32'(sel), 32'(k));
      check_eq("load_txd_hi", 32'(txd), 1);
    end
    wait_done("done_latency", (N + HDR) * BC);
    check_eq("busy_in_done", 32'(busy), 0);
    @(negedge clk);
    check_eq("done_width", 32'(done), 0);
    repeat (5) @(negedge clk);
    check_eq("sb_drain_basic", 32'(sb.size()), 0);

    // Start held while busy, then Start coincident with Done
    dc0 = done_cnt;
    push_frame(8'h11, 8'h22, 8'h80, 8'hFF);
    push_frame(8'h11, 8'h22, 8'h80, 8'hFF);
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    wait_to(100);
    start = 1'b0;
    wait_done("done_latency_ovl", (N + HDR) * BC);
    start = 1'b1;
    @(negedge clk); start = 1'b0; t0 = cyc;
    check_eq("restart_busy", 32'(busy), 1);
    check_eq("restart_load_txd", 32'(txd), 1);
    @(negedge clk);
    check_eq("restart_txd_fall", 32'(txd), 0);
    wait_done("done_latency_restart", (N + HDR) * BC);
    repeat (10) @(negedge clk);
    check_eq("no_queued_start", 32'(busy), 0);
    check_eq("done_count_ovl", 32'(done_cnt - dc0), 2);
    check_eq("sb_drain_ovl", 32'(sb.size()), 0);

    // snapshot: write before R1's LOAD is seen, write after it is not
    push_frame(8'h11, 8'h5A, 8'h80, 8'hFF);
    pulse_start();
    wait_to(HDR * BC + 10);
    regs[1] = 8'h5A;
    wait_done("done_latency_snap1", (N + HDR) * BC);
    regs[1] = 8'h22;
    push_frame(8'h11, 8'h22, 8'h80, 8'hFF);
    pulse_start();
    wait_to((1 + HDR) * BC + 2 + C + 2 * C);
    regs[1] = 8'h5A;
    wait_done("done_latency_snap2", (N + HDR) * BC);
    regs[1] = 8'h22;
    repeat (5) @(negedge clk);
    check_eq("sb_drain_snap", 32'(sb.size()), 0);

    // reset during DATA of byte 2
    if (HDR == 1) sb.push_back(8'hA5);
    sb.push_back(8'h11); sb.push_back(8'h22);
    pulse_start();
    wait_to((2 + HDR) * BC + 1 + C + 6);
    dc0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_txd", 32'(txd), 1);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_regsel", 32'(sel), 0);
    check_eq("midrst_done", 32'(done), 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("midrst_no_done", 32'(done_cnt - dc0), 0);
    check_eq("midrst_sb", 32'(sb.size()), 0);
    push_frame(8'h11, 8'h22, 8'h80, 8'hFF);
    pulse_start();
    check_eq("postrst_regsel", 32'(sel), 0);
    wait_done("done_latency_postrst", (N + HDR) * BC);
    repeat (5) @(negedge clk);
    check_eq("sb_drain_postrst", 32'(sb.size()), 0);

    // boundary: one register of 0x00 at two clocks per bit
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; t0 = cyc;
    check_eq("min_busy", 32'(busy2), 1);
    check_eq("min_regsel", 32'(sel2), 0);
    for (int d = 1; d < (1 + HDR) * BC2; d++) begin
      wait_to(d);
      check_eq("min_txd_bit", 32'(txd2), 32'(exp_bit2(d)));
    end
    n = 0;
    while (done2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check_eq("min_done_latency", (done2 === 1'b1) ? 32'(cyc - t0) : 32'hFFFF_FFFF, 32'((1 + HDR) * BC2));
    check_eq("min_busy_done", 32'(busy2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
